fxp_dot_acc: RTL and testbench

Streaming fixed-point dot-product accumulator that sits directly downstream of `fxp_mul`. It consumes the full-precision `y_full` products (2N bits, 2·FRAC fractional bits) one per cycle and sums each vector in a guarded wide accumulator. At the end of each vector it rounds and saturates the sum back to the N-bit, FRAC-fraction format, and presents it on a valid/ready output. It is the reduction stage for the Kalman filter's matrix-vector products.

---
 rtl/fxp_dot_acc.sv | 107 ++++++++++
 tb/tb_fxp_dot_acc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_dot_acc.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fxp_dot_acc : streaming fixed-point dot-product accumulator (round, sat)  |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module fxp_dot_acc #(
  parameter int N     = 20,
  parameter int FRAC  = 10,
  parameter int GUARD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_valid,
  output logic                  p_ready,
  input  logic signed [2*N-1:0] p_data,
  input  logic                  p_last,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic signed [N-1:0]   o_data,
  output logic                  o_sat,
  output logic                  o_ovf
);

  localparam int AW = 2*N + GUARD;
  localparam int RW = AW + 1;
  localparam int CW = GUARD + 1;

  localparam logic [CW-1:0]        CNT_LIM = CW'(2**GUARD);
  localparam logic [CW-1:0]        CNT_TOP = CW'(2**GUARD + 1);
  localparam logic signed [RW-1:0] HALF    = RW'(2**(FRAC-1));
  localparam logic signed [RW-1:0] OMAX    = {{(RW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN    = {{(RW-N+1){1'b1}}, {(N-1){1'b0}}};

  logic signed [AW-1:0] r_acc;
  logic [CW-1:0]        r_cnt;
  logic signed [AW-1:0] w_pext;
  logic signed [AW-1:0] w_sum;
  logic signed [RW-1:0] w_rnd;
  logic signed [RW-1:0] w_r;
  logic signed [N-1:0]  w_sat_data;
  logic                 w_accept;
  logic                 w_last_acc;
  logic                 w_pos_sat;
  logic                 w_neg_sat;
  logic                 w_ovf;

  assign p_ready    = !o_valid || o_ready;
  assign w_accept   = p_valid && p_ready;
  assign w_last_acc = w_accept && p_last;

  assign w_pext = {{GUARD{p_data[2*N-1]}}, p_data};
  assign w_sum  = r_acc + w_pext;

  // One extra bit so adding the rounding half can never wrap the sum.
  assign w_rnd = {w_sum[AW-1], w_sum} + HALF;
  assign w_r   = w_rnd >>> FRAC;

  assign w_pos_sat = (w_r > OMAX);
  assign w_neg_sat = (w_r < OMIN);

  always_comb begin
    w_sat_data = w_r[N-1:0];
    if (w_pos_sat) begin
      w_sat_data = OMAX[N-1:0];
    end else if (w_neg_sat) begin
      w_sat_data = OMIN[N-1:0];
    end
  end

  // r_cnt holds the terms before the current one; the last term pushes it past 2^GUARD.
  assign w_ovf = (r_cnt >= CNT_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (p_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        if (r_cnt != CNT_TOP) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sat   <= 1'b0;
      o_ovf   <= 1'b0;
    end else if (w_last_acc) begin
      o_valid <= 1'b1;
      o_data  <= w_sat_data;
      o_sat   <= w_pos_sat || w_neg_sat;
      o_ovf   <= w_ovf;
    end else if (o_valid && o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fxp_dot_acc.sv
`default_nettype none
// tb_fxp_dot_acc : randomized + directed self-checking bench against a behavioural model.
module tb_fxp_dot_acc;

  localparam int N     = 20;
  localparam int FRAC  = 10;
  localparam int GUARD = 4;
  localparam int AW    = 2*N + GUARD;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  p_valid = 1'b0;
  logic                  p_ready;
  logic signed [2*N-1:0] p_data = '0;
  logic                  p_last = 1'b0;
  logic                  o_valid;
  logic                  o_ready = 1'b1;
  logic signed [N-1:0]   o_data;
  logic                  o_sat;
  logic                  o_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  bit rmode     = 1'b0;
  bit ready_fix = 1'b1;

  fxp_dot_acc #(.N(N), .FRAC(FRAC), .GUARD(GUARD)) dut (
    .clk     (clk),
    .rst     (rst),
    .p_valid (p_valid),
    .p_ready (p_ready),
    .p_data  (p_data),
    .p_last  (p_last),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_sat   (o_sat),
    .o_ovf   (o_ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) o_ready = rmode ? ($urandom % 4 != 0) : ready_fix;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: unbounded term count, 44-bit wrapping sum, plain integer rounding.
  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_ov = 0, m_sat = 0, m_ovf = 0, started = 0;
  longint m_data = 0;
  longint s, r;

  function automatic longint wrap(input longint x);
    return (x <<< (64 - AW)) >>> (64 - AW);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_acc = 0; m_cnt = 0; m_ov = 0; m_data = 0; m_sat = 0; m_ovf = 0;
      started = 1;
    end else begin
      bit acc_ok;
      acc_ok = p_valid && (!m_ov || o_ready);
      if (m_ov && o_ready) m_ov = 0;
      if (acc_ok) begin
        s = wrap(m_acc + longint'(p_data));
        m_cnt++;
        if (p_last) begin
          r = (s + (64'sd1 <<< (FRAC-1))) >>> FRAC;
          if (r > (2**(N-1)) - 1) begin
            m_data = (2**(N-1)) - 1; m_sat = 1;
          end else if (r < -(2**(N-1))) begin
            m_data = -(2**(N-1)); m_sat = 1;
          end else begin
            m_data = r; m_sat = 0;
          end
          m_ovf = (m_cnt > 2**GUARD);
          m_ov  = 1;
          m_acc = 0;
          m_cnt = 0;
        end else begin
          m_acc = s;
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (started) begin
      chk("model_o_valid", longint'(o_valid), longint'(m_ov));
      chk("model_p_ready", longint'(p_ready), longint'(!m_ov || o_ready));
      if (m_ov) begin
        chk("model_o_data", longint'(o_data), m_data);
        chk("model_o_sat", longint'(o_sat), longint'(m_sat));
        chk("model_o_ovf", longint'(o_ovf), longint'(m_ovf));
      end
    end
  end

  task automatic push(input logic signed [2*N-1:0] d, input bit last);
    int waitc;
    waitc = 0;
    @(negedge clk);
    p_valid = 1'b1; p_data = d; p_last = last;
    #1;
    while (!p_ready) begin
      @(negedge clk);
      #1;
      waitc++;
      if (waitc > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL push_timeout: p_ready stuck at 0 for %0d cycles", waitc);
        break;
      end
    end
    @(posedge clk);
    #1 p_valid = 1'b0;
  endtask

  task automatic look();
    @(negedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #2;
    chk("reset_o_valid", longint'(o_valid), 0);
    chk("reset_o_data", longint'(o_data), 0);
    chk("reset_o_sat", longint'(o_sat), 0);
    chk("reset_o_ovf", longint'(o_ovf), 0);
    chk("reset_p_ready", longint'(p_ready), 1);

    // Three unit products -> 3.0
    push(40'sd1048576, 0); push(40'sd1048576, 0); push(40'sd1048576, 1);
    look();
    chk("unit_valid", longint'(o_valid), 1);
    chk("unit_data", longint'(o_data), 3072);
    chk("unit_sat", longint'(o_sat), 0);
    chk("unit_ovf", longint'(o_ovf), 0);

    // Round-half-up
    push(40'sd512, 1);  look(); chk("round_512", longint'(o_data), 1);
    push(-40'sd512, 1); look(); chk("round_m512", longint'(o_data), 0);
    push(-40'sd513, 1); look(); chk("round_m513", longint'(o_data), -1);
    push(40'sd1535, 1); look(); chk("round_1535", longint'(o_data), 1);

    // Saturation both ways
    push(40'sd536870912, 0); push(40'sd536870912, 1); look();
    chk("sat_pos_data", longint'(o_data), 524287);
    chk("sat_pos_flag", longint'(o_sat), 1);
    push(-40'sd1073741824, 1); look();
    chk("sat_neg_data", longint'(o_data), -524288);
    chk("sat_neg_flag", longint'(o_sat), 1);

    // Back-to-back single-term vectors with o_ready high: one result per cycle
    @(negedge clk);
    p_valid = 1'b1; p_last = 1'b1; p_data = 40'sd2048;
    @(negedge clk); #2;
    chk("b2b_first", longint'(o_data), 2);
    p_data = 40'sd3072;
    @(negedge clk); #2;
    chk("b2b_second", longint'(o_data), 3);
    chk("b2b_valid", longint'(o_valid), 1);
    p_valid = 1'b0;

    // Backpressure, then simultaneous consume + reload
    ready_fix = 1'b0;
    push(40'sd1048576, 1);
    @(negedge clk);
    p_valid = 1'b1; p_data = 40'sd2048; p_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      look();
      chk("bp_p_ready", longint'(p_ready), 0);
      chk("bp_o_data", longint'(o_data), 1024);
    end
    ready_fix = 1'b1;
    look();
    chk("bp_release_ready", longint'(p_ready), 1);
    look();
    chk("bp_reload_valid", longint'(o_valid), 1);
    chk("bp_reload_data", longint'(o_data), 2);
    p_valid = 1'b0;

    // 17-term vector overflows the guard
    for (int i = 0; i < 16; i++) push(40'sd1024, 0);
    push(40'sd1024, 1);
    look();
    chk("ovf_flag", longint'(o_ovf), 1);
    chk("ovf_data", longint'(o_data), 17);

    // Reset mid-vector discards the partial sum
    push(40'sd1048576, 0); push(40'sd1048576, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    #2;
    chk("rst_mid_valid", longint'(o_valid), 0);
    push(40'sd1048576, 1);
    look();
    chk("rst_mid_data", longint'(o_data), 1024);

    // Randomized vectors with random backpressure
    rmode = 1'b1;
    for (int v = 0; v < 250; v++) begin
      int len;
      len = 1 + int'($urandom % 20);
      for (int k = 0; k < len; k++) begin
        logic signed [2*N-1:0] d;
        d = 40'({$urandom, $urandom});
        d = d >>> ($urandom % 32);
        push(d, k == len - 1);
        if ($urandom % 5 == 0) @(negedge clk);
      end
    end
    rmode = 1'b0;
    ready_fix = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
